// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } demux_state_e;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;
    localparam int   CNT_W = 16;

endpackage

// File: rtl/stream_demux_out_stage.sv
// One-entry registered output slot: 1-cycle load-to-valid latency.
// Holds data/last while valid && !ready; accepts a new load while draining.
module out_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    output logic          empty_or_draining_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          last_q,  last_d;

    always_comb begin
        valid_d = valid_q && !ready_i;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o             = valid_q;
    assign data_o              = data_q;
    assign last_o              = last_q;
    assign empty_or_draining_o = !valid_q || ready_i;

endmodule

// File: rtl/stream_demux.sv
// 1:2 packet demux, select locked from first beat to last; 1-cycle latency.
// Stalls when the selected channel is full and not draining; optional counters under STREAM_DEMUX_CNT_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    input  logic          last_i,
    input  logic          sel_i,
    output logic          ready_o,
    output logic [DW-1:0] a_data_o,
    output logic          a_valid_o,
    output logic          a_last_o,
    input  logic          a_ready_i,
    output logic [DW-1:0] b_data_o,
    output logic          b_valid_o,
    output logic          b_last_o,
    input  logic          b_ready_i
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] a_pkts_o,
    output logic [CNT_W-1:0] b_pkts_o
`endif
);

    demux_state_e state_q, state_d;
    logic         lock_q,  lock_d;
    logic         eff_sel;
    logic         accept;
    logic         a_eod, b_eod;

    // ready_o never looks at valid_i, so no combinational valid->ready loop exists.
    assign eff_sel = (state_q == LOCK) ? lock_q : sel_i;
    assign ready_o = (eff_sel == SEL_A) ? a_eod : b_eod;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (accept) begin
            case (state_q)
                IDLE: if (!last_i) begin
                    state_d = LOCK;
                    lock_d  = sel_i;
                end
                LOCK: if (last_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    out_stage #(.DW(DW)) u_stage_a (
        .clk                 (clk),
        .reset_n             (reset_n),
        .load_i              (accept && (eff_sel == SEL_A)),
        .data_i              (data_i),
        .last_i              (last_i),
        .ready_i             (a_ready_i),
        .valid_o             (a_valid_o),
        .data_o              (a_data_o),
        .last_o              (a_last_o),
        .empty_or_draining_o (a_eod)
    );

    out_stage #(.DW(DW)) u_stage_b (
        .clk                 (clk),
        .reset_n             (reset_n),
        .load_i              (accept && (eff_sel == SEL_B)),
        .data_i              (data_i),
        .last_i              (last_i),
        .ready_i             (b_ready_i),
        .valid_o             (b_valid_o),
        .data_o              (b_data_o),
        .last_o              (b_last_o),
        .empty_or_draining_o (b_eod)
    );

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] a_pkts_q, a_pkts_d;
    logic [CNT_W-1:0] b_pkts_q, b_pkts_d;

    // A packet counts as delivered when its last beat leaves the stage.
    always_comb begin
        a_pkts_d = a_pkts_q;
        b_pkts_d = b_pkts_q;
        if (a_valid_o && a_ready_i && a_last_o && (a_pkts_q != '1))
            a_pkts_d = a_pkts_q + CNT_W'(1);
        if (b_valid_o && b_ready_i && b_last_o && (b_pkts_q != '1))
            b_pkts_d = b_pkts_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_pkts_q <= '0;
            b_pkts_q <= '0;
        end else begin
            a_pkts_q <= a_pkts_d;
            b_pkts_q <= b_pkts_d;
        end
    end

    assign a_pkts_o = a_pkts_q;
    assign b_pkts_o = b_pkts_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed vector table, mid-packet reset, then random traffic vs a queue model.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_i;
    logic       valid_i, last_i, sel_i;
    logic       ready_o;
    logic [7:0] a_data_o, b_data_o;
    logic       a_valid_o, a_last_o, a_ready_i;
    logic       b_valid_o, b_last_o, b_ready_i;
`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] a_pkts_o, b_pkts_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_demux #(.DW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .sel_i     (sel_i),
        .ready_o   (ready_o),
        .a_data_o  (a_data_o),
        .a_valid_o (a_valid_o),
        .a_last_o  (a_last_o),
        .a_ready_i (a_ready_i),
        .b_data_o  (b_data_o),
        .b_valid_o (b_valid_o),
        .b_last_o  (b_last_o),
        .b_ready_i (b_ready_i)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .a_pkts_o  (a_pkts_o),
        .b_pkts_o  (b_pkts_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       v;
        bit [7:0] d;
        bit       l, s, ar, br;
        bit       rdy;
        bit       av;
        bit [7:0] ad;
        bit       al, bv;
        bit [7:0] bd;
        bit       bl;
    } vec_t;

    function automatic vec_t mk(bit v, bit [7:0] d, bit l, bit s, bit ar, bit br, bit rdy,
                                bit av, bit [7:0] ad, bit al, bit bv, bit [7:0] bd, bit bl);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.s = s; r.ar = ar; r.br = br; r.rdy = rdy;
        r.av = av; r.ad = ad; r.al = al; r.bv = bv; r.bd = bd; r.bl = bl;
        return r;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    bit    in_pkt;
    bit    pkt_sel;
    int    cnt_a, cnt_b;

    task automatic drive(input bit v, input bit [7:0] d, input bit l, input bit s,
                         input bit ar, input bit br);
        valid_i = v; data_i = d; last_i = l; sel_i = s; a_ready_i = ar; b_ready_i = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_a_valid", 32'(a_valid_o), 32'd0);
        chk("rst_b_valid", 32'(b_valid_o), 32'd0);
        chk("rst_a_data",  32'(a_data_o),  32'd0);
        chk("rst_b_data",  32'(b_data_o),  32'd0);
        chk("rst_a_last",  32'(a_last_o),  32'd0);
        chk("rst_b_last",  32'(b_last_o),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        qa.delete(); qb.delete();
        in_pkt = 1'b0; pkt_sel = 1'b0; cnt_a = 0; cnt_b = 0;
    endtask

    vec_t tbl[12];

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        //            v     d      l     s     ar    br    rdy   av    ad     al    bv    bd     bl
        tbl[0]  = mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[1]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
        tbl[2]  = mk(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
        tbl[3]  = mk(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1);
        tbl[4]  = mk(1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1);
        tbl[5]  = mk(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1);
        tbl[6]  = mk(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
        tbl[7]  = mk(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[8]  = mk(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hB1, 1'b0);
        tbl[9]  = mk(1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hB2, 1'b1);
        tbl[10] = mk(1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        do_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].ar, tbl[i].br);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_a_valid", i), 32'(a_valid_o), 32'(tbl[i].av));
            chk($sformatf("vec%0d_b_valid", i), 32'(b_valid_o), 32'(tbl[i].bv));
            if (tbl[i].av) begin
                chk($sformatf("vec%0d_a_data", i), 32'(a_data_o), 32'(tbl[i].ad));
                chk($sformatf("vec%0d_a_last", i), 32'(a_last_o), 32'(tbl[i].al));
            end
            if (tbl[i].bv) begin
                chk($sformatf("vec%0d_b_data", i), 32'(b_data_o), 32'(tbl[i].bd));
                chk($sformatf("vec%0d_b_last", i), 32'(b_last_o), 32'(tbl[i].bl));
            end
        end

        // Reset arrives during beat 2 of a packet locked to A.
        @(negedge clk);
        drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_beat1_a_valid", 32'(a_valid_o), 32'd1);
        chk("mid_beat1_a_data",  32'(a_data_o),  32'h11);
        @(negedge clk);
        drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", 32'(a_valid_o), 32'd0);
        chk("mid_rst_b_valid", 32'(b_valid_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 8'hE5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mid_post_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_post_b_valid", 32'(b_valid_o), 32'd1);
        chk("mid_post_b_data",  32'(b_data_o),  32'hE5);
        chk("mid_post_a_valid", 32'(a_valid_o), 32'd0);

        // Random traffic against the packet/queue model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit       v, l, s, ar, br, tgt, exp_rdy, acc;
            bit [7:0] d;
            beat_t    nb;
            v  = ($urandom_range(0, 9) < 7);
            d  = 8'($urandom);
            l  = ($urandom_range(0, 3) == 0);
            s  = 1'($urandom);
            ar = ($urandom_range(0, 9) < 6);
            br = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            drive(v, d, l, s, ar, br);
            tgt = in_pkt ? pkt_sel : s;
            exp_rdy = tgt ? ((qa.size() == 0) || ar) : ((qb.size() == 0) || br);
            #1;
            chk("rnd_ready", 32'(ready_o), 32'(exp_rdy));
            @(posedge clk);
            if (qa.size() > 0 && ar) begin
                if (qa[0].l && cnt_a < 65535) cnt_a++;
                void'(qa.pop_front());
            end
            if (qb.size() > 0 && br) begin
                if (qb[0].l && cnt_b < 65535) cnt_b++;
                void'(qb.pop_front());
            end
            acc = v && exp_rdy;
            if (acc) begin
                nb.d = d;
                nb.l = l;
                if (tgt) qa.push_back(nb);
                else     qb.push_back(nb);
                if (!in_pkt && !l) begin
                    in_pkt  = 1'b1;
                    pkt_sel = s;
                end else if (in_pkt && l) begin
                    in_pkt = 1'b0;
                end
            end
            #1;
            chk("rnd_a_valid", 32'(a_valid_o), 32'(qa.size() > 0));
            chk("rnd_b_valid", 32'(b_valid_o), 32'(qb.size() > 0));
            if (qa.size() > 0) begin
                chk("rnd_a_data", 32'(a_data_o), 32'(qa[0].d));
                chk("rnd_a_last", 32'(a_last_o), 32'(qa[0].l));
            end
            if (qb.size() > 0) begin
                chk("rnd_b_data", 32'(b_data_o), 32'(qb[0].d));
                chk("rnd_b_last", 32'(b_last_o), 32'(qb[0].l));
            end
`ifdef STREAM_DEMUX_CNT_EN
            chk("rnd_a_pkts", 32'(a_pkts_o), 32'(cnt_a));
            chk("rnd_b_pkts", 32'(b_pkts_o), 32'(cnt_b));
`endif
            if (qa.size() > 1 || qb.size() > 1) begin
                chk("model_overflow", 32'(qa.size() + qb.size()), 32'd2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
